// File: rtl/rc4_coord_pkg.sv
// Shared types for the multi-core RC4 key-search coordinator.
package rc4_coord_pkg;

    localparam int KEY_W_DEF = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_FOUND,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/rc4_found_arbiter.sv
// Fixed-priority pick of the lowest-indexed core reporting a found key.
// Purely combinational; the coordinator registers the result.
module rc4_found_arbiter
    import rc4_coord_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = KEY_W_DEF
) (
    input  logic [NUM_CORES-1:0]       i_core_found,
    input  logic [NUM_CORES*KEY_W-1:0] i_core_key,
    output logic                       o_any_found,
    output logic [7:0]                 o_win_idx,
    output logic [KEY_W-1:0]           o_win_key
);

    // Scan high to low so the lowest set index is the last writer.
    always_comb begin
        o_any_found = 1'b0;
        o_win_idx   = 8'd0;
        o_win_key   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (i_core_found[i]) begin
                o_any_found = 1'b1;
                o_win_idx   = 8'(i);
                o_win_key   = i_core_key[i*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/rc4_core_coordinator.sv
// Launches NUM_CORES RC4 search cores, arbitrates their reports, stops them
// and holds one registered result until the next go.
module rc4_core_coordinator
    import rc4_coord_pkg::*;
#(
    parameter int          NUM_CORES = 4,
    parameter int          KEY_W     = KEY_W_DEF,
    parameter int unsigned TIMEOUT   = 2**24
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_go,
    output logic [NUM_CORES-1:0]       o_core_start,
    output logic                       o_stop_all,
    output logic [NUM_CORES*8-1:0]     o_core_init_val,
    output logic [7:0]                 o_total_cores,
    input  logic [NUM_CORES-1:0]       i_core_found,
    input  logic [NUM_CORES-1:0]       i_core_exhausted,
    input  logic [NUM_CORES*KEY_W-1:0] i_core_key,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_key_found,
    output logic [KEY_W-1:0]           o_found_key,
    output logic [7:0]                 o_found_core,
    output logic [31:0]                o_elapsed
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_any_found;
    logic [7:0]       w_win_idx;
    logic [KEY_W-1:0] w_win_key;
    logic             w_all_exh;
    logic             w_timeout;
    logic             w_go_ok;
    logic             w_start_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_key_found_nxt;

    rc4_found_arbiter #(
        .NUM_CORES (NUM_CORES),
        .KEY_W     (KEY_W)
    ) u_arb (
        .i_core_found (i_core_found),
        .i_core_key   (i_core_key),
        .o_any_found  (w_any_found),
        .o_win_idx    (w_win_idx),
        .o_win_key    (w_win_key)
    );

    generate
        for (genvar g = 0; g < NUM_CORES; g++) begin : g_init
            assign o_core_init_val[g*8 +: 8] = 8'(g);
        end
    endgenerate
    assign o_total_cores = 8'(NUM_CORES);

    assign w_all_exh = &i_core_exhausted;
    assign w_timeout = (TIMEOUT != 0) && (o_elapsed == 32'(TIMEOUT - 1));
    assign w_go_ok   = i_go && (r_state == ST_IDLE || r_state == ST_FOUND ||
                                r_state == ST_FAIL);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LAUNCH: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_any_found)                 w_state_nxt = ST_FOUND;
                else if (w_all_exh || w_timeout) w_state_nxt = ST_FAIL;
            end
            default:   if (w_go_ok) w_state_nxt = ST_LAUNCH;
        endcase
    end

    // Flags are decoded from the next state so they appear on the same edge.
    always_comb begin
        w_start_nxt     = (w_state_nxt == ST_LAUNCH);
        w_busy_nxt      = (w_state_nxt == ST_LAUNCH) || (w_state_nxt == ST_RUN);
        w_done_nxt      = (w_state_nxt == ST_FOUND) || (w_state_nxt == ST_FAIL);
        w_key_found_nxt = (w_state_nxt == ST_FOUND);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_core_start <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_stop_all   <= 1'b0;
            o_key_found  <= 1'b0;
        end else begin
            o_core_start <= {NUM_CORES{w_start_nxt}};
            o_busy       <= w_busy_nxt;
            o_done       <= w_done_nxt;
            o_stop_all   <= w_done_nxt;
            o_key_found  <= w_key_found_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_found_key  <= '0;
            o_found_core <= 8'd0;
            o_elapsed    <= 32'd0;
        end else if (w_go_ok) begin
            o_found_key  <= '0;
            o_found_core <= 8'd0;
            o_elapsed    <= 32'd0;
        end else if (r_state == ST_RUN) begin
            if (w_any_found) begin
                o_found_key  <= w_win_key;
                o_found_core <= w_win_idx;
            end else if (w_all_exh || w_timeout) begin
                o_found_key  <= '0;
            end else if (o_elapsed != 32'hFFFF_FFFF) begin
                o_elapsed    <= o_elapsed + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rc4_core_coordinator.sv
// Directed bench for rc4_core_coordinator: 4 cores, TIMEOUT of 16 cycles.
module tb_rc4_core_coordinator;

    localparam int NC = 4;
    localparam int KW = 22;

    logic            clk = 1'b0;
    logic            reset;
    logic            go;
    logic [NC-1:0]   core_start;
    logic            stop_all;
    logic [NC*8-1:0] core_init_val;
    logic [7:0]      total_cores;
    logic [NC-1:0]   core_found;
    logic [NC-1:0]   core_exhausted;
    logic [NC*KW-1:0] core_key;
    logic            busy;
    logic            done;
    logic            key_found;
    logic [KW-1:0]   found_key;
    logic [7:0]      found_core;
    logic [31:0]     elapsed;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [KW-1:0] K0 = 22'h0ABCDE;
    localparam logic [KW-1:0] K1 = 22'h12345A;
    localparam logic [KW-1:0] K2 = 22'h3A5F1C;
    localparam logic [KW-1:0] K3 = 22'h2F0F0F;

    always #5 clk = ~clk;

    rc4_core_coordinator #(
        .NUM_CORES (NC),
        .KEY_W     (KW),
        .TIMEOUT   (16)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_go             (go),
        .o_core_start     (core_start),
        .o_stop_all       (stop_all),
        .o_core_init_val  (core_init_val),
        .o_total_cores    (total_cores),
        .i_core_found     (core_found),
        .i_core_exhausted (core_exhausted),
        .i_core_key       (core_key),
        .o_busy           (busy),
        .o_done           (done),
        .o_key_found      (key_found),
        .o_found_key      (found_key),
        .o_found_core     (found_core),
        .o_elapsed        (elapsed)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status flags packed as {core_start, busy, done, key_found, stop_all}.
    function automatic logic [63:0] flags();
        return 64'({core_start, busy, done, key_found, stop_all});
    endfunction

    task automatic launch();
        go = 1'b1;
        step();
        go = 1'b0;
        step();
    endtask

    initial begin
        reset          = 1'b1;
        go             = 1'b0;
        core_found     = '0;
        core_exhausted = '0;
        core_key       = {K3, K2, K1, K0};
        #2;
        chk("rst_flags", flags(), 64'h0);
        chk("rst_key", 64'(found_key), 64'h0);
        chk("rst_core", 64'(found_core), 64'h0);
        chk("rst_elapsed", 64'(elapsed), 64'h0);
        chk("init_val", 64'(core_init_val), 64'h03020100);
        chk("total_cores", 64'(total_cores), 64'h4);
        step();
        reset = 1'b0;
        step();

        // Launch: one cycle of all-ones start, then RUN with elapsed 0.
        go = 1'b1;
        step();
        go = 1'b0;
        chk("launch_flags", flags(), {59'h0, 4'hF, 1'b1, 3'b000});
        step();
        chk("run_flags", flags(), {59'h0, 4'h0, 1'b1, 3'b000});
        chk("run_elapsed0", 64'(elapsed), 64'h0);

        // Single find on core 2.
        core_found = 4'b0100;
        step();
        core_found = 4'b0000;
        chk("found_flags", flags(), {59'h0, 4'h0, 1'b0, 3'b111});
        chk("found_key2", 64'(found_key), 64'(K2));
        chk("found_core2", 64'(found_core), 64'h2);
        step();
        chk("found_hold", 64'(found_key), 64'(K2));

        // Restart from FOUND clears results on the launch edge.
        go = 1'b1;
        step();
        go = 1'b0;
        chk("relaunch_flags", flags(), {59'h0, 4'hF, 1'b1, 3'b000});
        chk("relaunch_key", 64'(found_key), 64'h0);
        chk("relaunch_core", 64'(found_core), 64'h0);
        step();
        step();
        chk("elapsed1", 64'(elapsed), 64'h1);

        // Two finds at once: lowest index wins.
        core_found = 4'b1010;
        step();
        core_found = 4'b0000;
        chk("prio_core", 64'(found_core), 64'h1);
        chk("prio_key", 64'(found_key), 64'(K1));
        chk("prio_elapsed", 64'(elapsed), 64'h1);

        // All exhausted, no find.
        launch();
        core_exhausted = 4'b1111;
        step();
        core_exhausted = 4'b0000;
        chk("exh_flags", flags(), {59'h0, 4'h0, 1'b0, 3'b101});
        chk("exh_key", 64'(found_key), 64'h0);

        // All exhausted together with a find on core 0.
        launch();
        core_exhausted = 4'b1111;
        core_found     = 4'b0001;
        step();
        core_exhausted = 4'b0000;
        core_found     = 4'b0000;
        chk("exh_found_flags", flags(), {59'h0, 4'h0, 1'b0, 3'b111});
        chk("exh_found_core", 64'(found_core), 64'h0);
        chk("exh_found_key", 64'(found_key), 64'(K0));

        // Timeout after 16 RUN cycles, with an ignored go along the way.
        launch();
        for (int i = 1; i <= 15; i++) begin
            go = (i == 6);
            step();
            go = 1'b0;
            if (i == 6) begin
                chk("go_in_run_flags", flags(), {59'h0, 4'h0, 1'b1, 3'b000});
                chk("go_in_run_elapsed", 64'(elapsed), 64'h6);
            end
        end
        chk("pre_to_flags", flags(), {59'h0, 4'h0, 1'b1, 3'b000});
        chk("pre_to_elapsed", 64'(elapsed), 64'd15);
        step();
        chk("to_flags", flags(), {59'h0, 4'h0, 1'b0, 3'b101});
        chk("to_elapsed", 64'(elapsed), 64'd15);
        chk("to_key", 64'(found_key), 64'h0);

        // Found on core 3 to leave a result, then reset mid-RUN of the next search.
        launch();
        core_found = 4'b1000;
        step();
        core_found = 4'b0000;
        chk("core3_key", 64'(found_key), 64'(K3));
        launch();
        step();
        chk("mid_run_elapsed", 64'(elapsed), 64'h1);
        reset = 1'b1;
        #1;
        chk("async_rst_flags", flags(), 64'h0);
        chk("async_rst_elapsed", 64'(elapsed), 64'h0);
        chk("async_rst_key", 64'(found_key), 64'h0);
        step();
        reset = 1'b0;
        go = 1'b1;
        step();
        go = 1'b0;
        chk("post_rst_launch", flags(), {59'h0, 4'hF, 1'b1, 3'b000});
        step();
        chk("post_rst_run", flags(), {59'h0, 4'h0, 1'b1, 3'b000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_core_coordinator.md
# rc4_core_coordinator

Control-side counterpart of the encapsulated multi-core RC4 key-search cores. It launches `NUM_CORES` cores with distinct interleave offsets and collects their `correct_key_found` / exhausted reports. It picks one winning key, broadcasts `stop_all`, and presents a single result to the top level. It sits between the top-level start/result logic (switches/LEDs/HEX) and the array of `rc4_encapsulated` instances.

## Interface
Parameters:
- `NUM_CORES`, 4: number of cores driven; 1..255.
- `KEY_W`, 22: secret key width.
- `TIMEOUT`, 2**24: maximum RUN cycles before declaring failure; 0 disables the timeout.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `go` in 1: single-cycle pulse; begin a new search.
- `core_start` out `NUM_CORES`: per-core start pulse.
- `stop_all` out 1: freeze all cores.
- `core_init_val` out `NUM_CORES*8`: packed; slice i = i.
- `total_cores` out 8: constant `NUM_CORES`.
- `core_found` in `NUM_CORES`: per-core `correct_key_found`, level.
- `core_exhausted` in `NUM_CORES`: per-core "key space finished, no match", level.
- `core_key` in `NUM_CORES*KEY_W`: packed per-core `secret_key`.
- `busy` out 1: search launched and not finished.
- `done` out 1: result valid; held until the next `go`.
- `key_found` out 1: with `done`, indicates success.
- `found_key` out `KEY_W`: winning key.
- `found_core` out 8: index of the winning core.
- `elapsed` out 32: RUN cycle count, saturating.

## Operation
- States: IDLE, LAUNCH, RUN, FOUND, FAIL.
- IDLE/FOUND/FAIL, `go`=1 → LAUNCH.
  - Clear `done`, `key_found`, `found_key`, `found_core`, `elapsed`.
  - `stop_all` drops.
- LAUNCH: `core_start` all-ones for exactly one cycle → RUN.
- RUN, evaluated each cycle in this priority order:
  1. Any `core_found` bit set → FOUND. Lowest set index wins. Latch its `core_key` slice into `found_key` and the index into `found_core`.
  2. Else all `core_exhausted` bits set → FAIL.
  3. Else `TIMEOUT`≠0 and `elapsed`==`TIMEOUT`-1 → FAIL.
  4. Else stay in RUN; `elapsed`++ (saturates at 2^32-1).
- FOUND: `done`=1, `key_found`=1, `stop_all`=1.
- FAIL: `done`=1, `key_found`=0, `stop_all`=1, `found_key`=0.
- `go` while in LAUNCH or RUN is ignored.
- `core_found`/`core_exhausted` are ignored outside RUN.
- `core_init_val` and `total_cores` are constants, independent of state.

## Timing
- Reset values:
  - State IDLE.
  - `core_start`=0, `stop_all`=0, `busy`=0, `done`=0, `key_found`=0.
  - `found_key`=0, `found_core`=0, `elapsed`=0.
- All outputs are registered except `core_init_val` and `total_cores`.
- `go` high at edge t → LAUNCH from t+1: `core_start`=all-ones and `busy`=1 during cycle t+1; `core_start` returns to 0 at t+2.
- RUN begins at t+2. `elapsed` counts RUN cycles; it is 0 in the first RUN cycle.
- `core_found` sampled high at edge r in RUN → from r+1: `done`=1, `key_found`=1, `stop_all`=1, `busy`=0, and `found_key` valid. Result latency is 1 cycle.
- Simultaneous events in the same cycle:
  - found and all-exhausted → FOUND.
  - found and timeout → FOUND.
  - several found bits → lowest index wins.
- A found bit that was already high in the first RUN cycle counts as a find; the cores guarantee it is low after start.
- Asynchronous `reset` mid-RUN → immediately IDLE with all reset values; cores are not stopped by the coordinator (they share `reset`).
- `go` in FOUND/FAIL restarts the search: LAUNCH next cycle, results cleared in that same edge.

## Structure
- Package `rc4_coord_pkg`: `state_t` enum (IDLE, LAUNCH, RUN, FOUND, FAIL) and `KEY_W` default constant.
- Sub-module `rc4_found_arbiter`: fixed-priority encoder.
  - Inputs: `core_found`, `core_key`.
  - Outputs: `any_found`, `win_idx`, `win_key`.
  - Combinational; parameterised by `NUM_CORES`, `KEY_W`.
- Top: FSM, `elapsed` counter, result registers.

## Test plan
- Reset then `go`, `NUM_CORES`=4 → `core_start`=4'b1111 for exactly one cycle, `busy`=1, and `core_init_val` slices read 0,1,2,3.
- In RUN, drive `core_found`=4'b0100 with core 2 key 22'h3A5F1C → next cycle `done`=1, `key_found`=1, `found_key`=22'h3A5F1C, `found_core`=2, `stop_all`=1.
- Drive `core_found`=4'b1010 in the same cycle → `found_core`=1, with core 1's key latched.
- Set `core_exhausted`=4'b1111 with no find → FAIL: `done`=1, `key_found`=0, `found_key`=0. Separately, all-exhausted together with `core_found`=4'b0001 → FOUND, `found_core`=0.
- With `TIMEOUT`=16 and no core activity → FAIL after 16 RUN cycles, `elapsed`=15. A `go` pulse during RUN has no effect.
- Assert `reset` mid-RUN → all outputs return to reset values immediately. A subsequent `go` launches again, and `go` from FOUND clears the previous result on the launch edge.
